gate_sweep_ctrl: RTL and testbench
==================================

Name: gate_sweep_ctrl

Overview:
- Sequencer that owns the input pins of a small combinational gate under test (e.g. a NAND-built OR).
- Steps the gate through every input combination and holds each vector for a settle window.
- Samples the gate output and compares it against an expected truth table.
- Reports pass/fail, mismatch count and a per-vector fail mask; it is the on-chip replacement for a hand-written truth-table bench.

Parameters:
- N_IN, 2, number of gate inputs; vector count V = 2**N_IN (legal 1..4).
- SETTLE_CYCLES, 1, extra cycles each vector is held before sampling; each vector is held SETTLE_CYCLES+1 cycles (legal 0..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; accepted only when idle.
- exp_table  input  V  expected gate output; bit i = expected y when gate_in = i.
- gate_in  output  N_IN  drive to the gate inputs; bit N_IN-1 = first operand (a), bit 0 = last (b).
- gate_y  input  1  gate output under test.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when a sweep finishes.
- pass  output  1  last sweep had zero mismatches.
- err_count  output  N_IN+1  mismatch count of the last sweep (0..V).
- fail_mask  output  V  bit i set if vector i mismatched.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - gate_in=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0.
  - Settle counter and captured table are cleared.
  - A reset in the middle of a sweep aborts it immediately. No done pulse is produced.
- States: IDLE, APPLY, FINISH.
- IDLE:
  - When start=1 at an edge, capture exp_table internally.
  - Clear err_count and fail_mask; set pass=0.
  - Load gate_in=0 and settle counter=0, set busy=1, and go to APPLY.
  - start is ignored in APPLY and FINISH.
  - Changes to exp_table after capture have no effect on the current sweep.
- APPLY:
  - gate_in holds the current vector index i.
  - Each edge with counter < SETTLE_CYCLES increments the counter.
  - At the edge where counter == SETTLE_CYCLES, gate_y is sampled and compared with the captured bit i.
  - On a mismatch, set fail_mask[i] and increment err_count.
  - At that same edge: if i < V-1, set gate_in=i+1 and counter=0; if i == V-1, go to FINISH. gate_in does not wrap to 0 inside the sweep.
- FINISH:
  - Lasts one cycle with done=1 and busy=0.
  - pass = (err_count == 0), registered so it is valid in the same cycle as done.
  - Then return to IDLE.
  - gate_in returns to 0 on entry to IDLE.
- Results hold until the next accepted start or reset.
- Latency: start edge to done high = V*(SETTLE_CYCLES+1)+1 cycles. For defaults this is 9.
- gate_y is sampled only at compare edges. Glitches at other times are ignored.
- err_count never overflows because its width covers V.
- Back-to-back sweeps: start asserted during the FINISH cycle is ignored. It is accepted on the first IDLE cycle.

Optional Feature:
- Macro GATE_SWEEP_STOP_ON_FAIL_EN.
- When defined:
  - The first mismatch ends the sweep. At that compare edge, go straight to FINISH.
  - err_count=1 and fail_mask has exactly that one bit set. pass=0.
  - gate_in keeps the failing vector index during the FINISH cycle, for debug.
- When undefined: all V vectors are always applied, as described above.

Test Plan:
- Good OR gate, defaults, exp_table=4'b1110 → gate_in steps 0,1,2,3, two cycles each; done 9 cycles after start; pass=1, err_count=0, fail_mask=0.
- Gate tied to AND, exp_table=4'b1110 → vectors 1 and 2 mismatch; pass=0, err_count=2, fail_mask=4'b0110.
- Same AND gate with GATE_SWEEP_STOP_ON_FAIL_EN → done after 2*2+1=5 cycles; err_count=1, fail_mask=4'b0010, gate_in=1 during done.
- SETTLE_CYCLES=3, gate_y delayed 2 cycles from gate_in, exp_table=4'b1110 → pass=1. The same delayed gate with SETTLE_CYCLES=0 → pass=0.
- Pulse rst_n low at cycle 4 of a sweep → all outputs 0 asynchronously and no done pulse. A fresh start then completes normally with pass=1.
- Assert start during APPLY and during FINISH, and change exp_table mid-sweep → no restart; results follow the captured table; the start held into IDLE launches one new sweep.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl -- on-chip truth-table sweeper for a small combinational gate.
//
// Drives every input combination onto gate_in in ascending order. Each vector is
// held SETTLE_CYCLES+1 cycles. At the last cycle of the hold, gate_y is sampled and
// compared with the expected table that was captured at start.
//
// Optional build macro: GATE_SWEEP_STOP_ON_FAIL_EN
//   The sweep ends at the first mismatch. gate_in keeps the failing index
//   during the done cycle.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   async active-low reset
//   start      in   begin a sweep (accepted in IDLE only)
//   exp_table  in   [V-1:0] expected y; bit i is the expected y for gate_in == i
//   gate_in    out  [N_IN-1:0] gate operands; MSB = a, LSB = b
//   gate_y     in   gate output under test
//   busy       out  high while vectors are being applied
//   done       out  one-cycle pulse at the end of a sweep
//   pass       out  last sweep had no mismatches
//   err_count  out  [N_IN:0] mismatches in the last sweep
//   fail_mask  out  [V-1:0] bit i set if vector i mismatched
module gate_sweep_ctrl #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   exp_table,
  output logic [N_IN-1:0]        gate_in,
  input  logic                   gate_y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic [(1<<N_IN)-1:0]   fail_mask
);

  localparam int V = 1 << N_IN;

  typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] gin_q, gin_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [V-1:0]    exp_q, exp_d;
  logic [N_IN:0]   err_q, err_d;
  logic [V-1:0]    mask_q, mask_d;
  logic            pass_q, pass_d;
  logic            mis;
  logic            last_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gin_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gin_q   <= gin_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gin_d    = gin_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    err_d    = err_q;
    mask_d   = mask_q;
    pass_d   = pass_q;
    mis      = 1'b0;
    last_vec = (gin_q == N_IN'(V - 1));
    case (state_q)
      IDLE: begin
        gin_d = '0;
        if (start) begin
          exp_d   = exp_table;
          err_d   = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
          cnt_d   = '0;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (cnt_q != 4'(SETTLE_CYCLES)) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          // Compare edge: gate_y is only looked at here, glitches elsewhere are ignored.
          mis = (gate_y != exp_q[gin_q]);
          if (mis) begin
            mask_d[gin_q] = 1'b1;
            err_d         = err_q + (N_IN+1)'(1);
          end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
          if (mis) begin
            // Leave gin alone so the failing vector is visible during done.
            state_d = FINISH;
            pass_d  = 1'b0;
          end else if (last_vec) begin
            state_d = FINISH;
            pass_d  = (err_d == '0);
          end else begin
            gin_d = gin_q + N_IN'(1);
            cnt_d = '0;
          end
`else
          if (last_vec) begin
            state_d = FINISH;
            pass_d  = (err_d == '0);
          end else begin
            gin_d = gin_q + N_IN'(1);
            cnt_d = '0;
          end
`endif
        end
      end
      FINISH: begin
        state_d = IDLE;
        gin_d   = '0;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gate_in   = gin_q;
  assign busy      = (state_q == APPLY);
  assign done      = (state_q == FINISH);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl.
// The main instance uses the default parameters. Its gate is either OR or AND.
// Two extra instances (SETTLE 3 and SETTLE 0) drive an OR gate whose output is delayed by two flops.
module tb_gate_sweep_ctrl;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
  localparam int         AND_LAT  = 5;
  localparam int         AND_ERR  = 1;
  localparam logic [3:0] AND_MASK = 4'b0010;
  localparam int         FAST_ERR = 1;
`else
  localparam int         AND_LAT  = 9;
  localparam int         AND_ERR  = 2;
  localparam logic [3:0] AND_MASK = 4'b0110;
  localparam int         FAST_ERR = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] exp_table = 4'b0000;
  logic [1:0] gate_in;
  logic       gate_y;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;
  logic       gate_mode = 1'b0;  // 0 = OR, 1 = AND

  logic       start_sd = 1'b0;
  logic [3:0] exp_sd = 4'b1110;
  logic [1:0] gin_s, gin_f, d1s, d2s, d1f, d2f;
  logic       busy_s, done_s, pass_s, busy_f, done_f, pass_f;
  logic [2:0] err_s, err_f;
  logic [3:0] mask_s, mask_f;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [1:0] trace [0:15];
  logic [1:0] gin_at_done;

  always #5 clk = ~clk;

  assign gate_y = gate_mode ? (&gate_in) : (|gate_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1s <= '0; d2s <= '0; d1f <= '0; d2f <= '0;
    end else begin
      d1s <= gin_s; d2s <= d1s; d1f <= gin_f; d2f <= d1f;
    end
  end

  gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_table(exp_table), .gate_in(gate_in),
    .gate_y(gate_y), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_mask(fail_mask));

  gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(3)) u_slow (
    .clk(clk), .rst_n(rst_n), .start(start_sd), .exp_table(exp_sd), .gate_in(gin_s),
    .gate_y(|d2s), .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .fail_mask(mask_s));

  gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .start(start_sd), .exp_table(exp_sd), .gate_in(gin_f),
    .gate_y(|d2f), .busy(busy_f), .done(done_f), .pass(pass_f), .err_count(err_f),
    .fail_mask(mask_f));

  // Launch one sweep on the main instance and count edges until done (bounded).
  task automatic sweep(input logic [3:0] tbl);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    exp_table = tbl;
    start = 1'b1;
    lat = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
      trace[lat % 16] = gate_in;
      if (done) begin seen = 1'b1; gin_at_done = gate_in; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if (gate_in !== 2'd0) begin errors++; $display("FAIL rst_gate_in got %0d want 0", gate_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %0b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL rst_pass got %0b want 0", pass); end
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL rst_err got %0d want 0", err_count); end
    checks++; if (fail_mask !== 4'd0) begin errors++; $display("FAIL rst_mask got %b want 0000", fail_mask); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good_or;
    gate_mode = 1'b0;
    sweep(4'b1110);
    checks++; if (lat !== 9) begin errors++; $display("FAIL or_latency got %0d want 9", lat); end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (trace[k] !== 2'((k - 1) / 2)) begin
        errors++; $display("FAIL or_gate_in_step%0d got %0d want %0d", k, trace[k], (k - 1) / 2);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL or_busy_at_done got %0b want 0", busy); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL or_pass got %0b want 1", pass); end
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL or_err got %0d want 0", err_count); end
    checks++; if (fail_mask !== 4'd0) begin errors++; $display("FAIL or_mask got %b want 0000", fail_mask); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL or_done_pulse got %0b want 0", done); end
    checks++; if (gate_in !== 2'd0) begin errors++; $display("FAIL or_idle_gate_in got %0d want 0", gate_in); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL or_pass_hold got %0b want 1", pass); end
  endtask

  task automatic test_and_gate;
    gate_mode = 1'b1;
    sweep(4'b1110);
    checks++; if (lat !== AND_LAT) begin errors++; $display("FAIL and_latency got %0d want %0d", lat, AND_LAT); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL and_pass got %0b want 0", pass); end
    checks++; if (err_count !== 3'(AND_ERR)) begin errors++; $display("FAIL and_err got %0d want %0d", err_count, AND_ERR); end
    checks++; if (fail_mask !== AND_MASK) begin errors++; $display("FAIL and_mask got %b want %b", fail_mask, AND_MASK); end
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    checks++; if (gin_at_done !== 2'd1) begin errors++; $display("FAIL and_gate_in_at_done got %0d want 1", gin_at_done); end
`else
    checks++; if (gin_at_done !== 2'd3) begin errors++; $display("FAIL and_gate_in_at_done got %0d want 3", gin_at_done); end
`endif
    @(negedge clk);
  endtask

  task automatic test_delay;
    int n, lat_s;
    bit seen_s, seen_f;
    seen_s = 1'b0; seen_f = 1'b0; n = 0; lat_s = 0;
    @(negedge clk);
    start_sd = 1'b1;
    for (int k = 0; k < 60 && !(seen_s && seen_f); k++) begin
      @(posedge clk); #1;
      start_sd = 1'b0;
      n++;
      if (done_s && !seen_s) begin seen_s = 1'b1; lat_s = n; end
      if (done_f) seen_f = 1'b1;
    end
    checks++; if (lat_s !== 17) begin errors++; $display("FAIL slow_latency got %0d want 17", lat_s); end
    checks++; if (!seen_f) begin errors++; $display("FAIL fast_done got 0 want 1"); end
    checks++; if (pass_s !== 1'b1) begin errors++; $display("FAIL slow_pass got %0b want 1", pass_s); end
    checks++; if (err_s !== 3'd0) begin errors++; $display("FAIL slow_err got %0d want 0", err_s); end
    checks++; if (pass_f !== 1'b0) begin errors++; $display("FAIL fast_pass got %0b want 0", pass_f); end
    checks++; if (err_f !== 3'(FAST_ERR)) begin errors++; $display("FAIL fast_err got %0d want %0d", err_f, FAST_ERR); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dones;
    gate_mode = 1'b0;
    dones = 0;
    @(negedge clk);
    exp_table = 4'b1110;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dones++;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_rst got %0b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %0b want 0", busy); end
    checks++; if (gate_in !== 2'd0) begin errors++; $display("FAIL mid_rst_gate_in got %0d want 0", gate_in); end
    checks++; if (err_count !== 3'd0 || fail_mask !== 4'd0 || pass !== 1'b0) begin
      errors++; $display("FAIL mid_rst_results got err=%0d mask=%b pass=%0b want 0/0000/0", err_count, fail_mask, pass);
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
      if (k == 2) rst_n = 1'b1;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL mid_rst_no_done got %0d want 0", dones); end
    sweep(4'b1110);
    checks++; if (lat !== 9) begin errors++; $display("FAIL mid_restart_latency got %0d want 9", lat); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL mid_restart_pass got %0b want 1", pass); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    bit seen;
    gate_mode = 1'b1;
    seen = 1'b0; n = 0;
    @(negedge clk);
    exp_table = 4'b1110;
    start = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) exp_table = 4'b1000;  // AND truth table; only the next capture may see it
      if (done) seen = 1'b1;
    end
    checks++; if (n !== AND_LAT) begin errors++; $display("FAIL b2b_latency got %0d want %0d", n, AND_LAT); end
    checks++; if (err_count !== 3'(AND_ERR)) begin errors++; $display("FAIL b2b_captured_err got %0d want %0d", err_count, AND_ERR); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got busy=%0b done=%0b want 0/0", busy, done);
    end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_relaunch got busy=%0b want 1", busy); end
    start = 1'b0;
    seen = 1'b0; n = 1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL b2b_second_latency got %0d want 9", n); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL b2b_second_pass got %0b want 1", pass); end
    checks++; if (err_count !== 3'd0) begin errors++; $display("FAIL b2b_second_err got %0d want 0", err_count); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_single_relaunch got busy=%0b want 0", busy); end
  endtask

  initial begin
    test_reset;
    test_good_or;
    test_and_gate;
    test_delay;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
